// File: rtl/scope_renderer.sv
// Pipelined pixel renderer: overlays NUM_CH sample traces, a dashed trigger marker and a grid
// onto the active video area, reading samples through a one-cycle synchronous RAM port.
module scope_renderer #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int NUM_CH   = 2,
    parameter int COORD_W  = 10,
    parameter int GRID_X   = 60,
    parameter int GRID_Y   = 48,
    parameter int RGB_W    = 12
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [COORD_W-1:0]        h,
    input  logic [COORD_W-1:0]        v,
    input  logic                      vidstate,
    input  logic                      mode_connect,
    input  logic [NUM_CH-1:0]         ch_enable,
    input  logic [NUM_CH*RGB_W-1:0]   ch_color,
    input  logic [RGB_W-1:0]          grid_color,
    input  logic [RGB_W-1:0]          trig_color,
    input  logic [COORD_W-1:0]        trig_level,
    output logic [COORD_W-1:0]        sample_addr,
    input  logic [NUM_CH*COORD_W-1:0] sample_data,
    output logic [RGB_W-1:0]          rgb,
    output logic                      rgb_valid
);

    localparam logic [COORD_W-1:0] H_LIM   = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_LIM   = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] V_LAST  = COORD_W'(V_ACTIVE - 1);
    localparam logic [COORD_W-1:0] GX_LAST = COORD_W'(GRID_X - 1);
    localparam logic [COORD_W-1:0] GY_LAST = COORD_W'(GRID_Y - 1);

    // S1 pipeline state; col_q/row_q are h1 mod GRID_X and v1 mod GRID_Y
    logic [COORD_W-1:0] h1, v1, col_q, row_q;
    logic               act1, mode_q;
    logic [NUM_CH-1:0]  en_q;
    logic [COORD_W-1:0] prev_q [NUM_CH];

    logic [COORD_W-1:0] col_next, row_next;
    logic               act0;

    assign sample_addr = rst ? '0 : h;
    assign act0        = (h < H_LIM) && (v < V_LIM) && vidstate;

    // Counters restart at h==0 / v==0 and advance whenever the coordinate moves on
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        col_next = col_q;
        row_next = row_q;
        if (h == '0)
            col_next = '0;
        else if (h != h1)
            col_next = (col_q == GX_LAST) ? '0 : col_q + 1'b1;
        if (v == '0)
            row_next = '0;
        else if (v != v1)
            row_next = (row_q == GY_LAST) ? '0 : row_q + 1'b1;
    end

    logic [COORD_W-1:0] cur [NUM_CH];
    logic [NUM_CH-1:0]  hit;
    logic [NUM_CH-1:0]  en_eff;
    logic               line_start, mode_eff;
    logic [RGB_W-1:0]   color_next;

    always_comb begin
        logic [COORD_W-1:0] prv, lo, hi;
        line_start = (h1 == '0);
        mode_eff   = line_start ? mode_connect : mode_q;
        en_eff     = line_start ? ch_enable : en_q;
        prv        = '0;
        lo         = '0;
        hi         = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            cur[k] = sample_data[k*COORD_W +: COORD_W];
            // Column 0 never connects back to the previous line's last sample
            prv    = line_start ? cur[k] : prev_q[k];
            lo     = (prv < cur[k]) ? prv : cur[k];
            hi     = (prv < cur[k]) ? cur[k] : prv;
            hi     = (hi > V_LAST) ? V_LAST : hi;
            hit[k] = en_eff[k] && (mode_eff ? (v1 >= lo && v1 <= hi) : (v1 == cur[k]));
        end
        color_next = '0;
        if (col_q == '0 || row_q == '0)
            color_next = grid_color;
        if (v1 == trig_level && !h1[2])
            color_next = trig_color;
        for (int k = NUM_CH - 1; k >= 0; k--)
            if (hit[k])
                color_next = ch_color[k*RGB_W +: RGB_W];
        if (!act1)
            color_next = '0;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h1        <= '0;
            v1        <= '0;
            col_q     <= '0;
            row_q     <= '0;
            act1      <= 1'b0;
            mode_q    <= 1'b0;
            en_q      <= '0;
            // NOTE: the prev-sample array is a handful of flops, not RAM, so it is reset like any register.
            for (int k = 0; k < NUM_CH; k++)
                prev_q[k] <= '0;
            rgb       <= '0;
            rgb_valid <= 1'b0;
        end else begin
            h1    <= h;
            v1    <= v;
            act1  <= act0;
            col_q <= col_next;
            row_q <= row_next;
            if (line_start) begin
                mode_q <= mode_connect;
                en_q   <= ch_enable;
            end
            if (act1)
                for (int k = 0; k < NUM_CH; k++)
                    prev_q[k] <= cur[k];
            rgb       <= color_next;
            rgb_valid <= act1;
        end
    end

endmodule
